// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and encodings for the LEGv8 instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_BR_REG = 2'b10;
    localparam logic [1:0] PS_BR_REL = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC computation from the control word's PS and k fields.
module pc_next_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        ps,
    input  logic [ADDR_W-1:0] k,
    input  logic [ADDR_W-1:0] reg_a,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    // All arithmetic wraps modulo 2^64; wrap is not a fault.
    always_comb begin
        next_pc = pc;
        unique case (ps)
            PS_HOLD:   next_pc = pc;
            PS_INC:    next_pc = pc + 64'd4;
            PS_BR_REG: next_pc = reg_a;
            PS_BR_REL: next_pc = pc + {k[ADDR_W-3:0], 2'b00};
            default:   next_pc = pc;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// PC holder and instruction fetcher feeding the LEGv8 control decoder.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         ps,
    input  logic [ADDR_W-1:0]  k,
    input  logic [ADDR_W-1:0]  reg_a,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               fault
);

    state_t            state;
    logic [ADDR_W-1:0] next_pc;
    logic              misaligned;

    pc_next_calc u_pc_next_calc (
        .pc         (pc),
        .ps         (ps),
        .k          (k),
        .reg_a      (reg_a),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign fault     = (state == ST_FAULT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!stall && ps != PS_HOLD) begin
                        instr_valid <= 1'b0;
                        // A bad target leaves pc at the last good address.
                        if (misaligned) begin
                            state <= ST_FAULT;
                        end else begin
                            pc    <= next_pc;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FAULT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    instr_valid <= 1'b0;
                    state       <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h100;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ps;
    logic [63:0] k;
    logic [63:0] reg_a;
    logic        stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic [63:0] pc;
    logic        fault;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .ps          (ps),
        .k           (k),
        .reg_a       (reg_a),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serve one fetch: waits idle cycles, then ack; checks request shape.
    task automatic fetch(input int waits, input logic [63:0] addr);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            check("wait_req", 64'(imem_req), 64'd1);
            check("wait_addr", imem_addr, addr);
            check("wait_valid", 64'(instr_valid), 64'd0);
            @(negedge clock);
        end
        check("ack_req", 64'(imem_req), 64'd1);
        check("ack_addr", imem_addr, addr);
        imem_rdata = word(addr);
        imem_ack   = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        check("f_valid", 64'(instr_valid), 64'd1);
        check("f_instr", 64'(instr), 64'(word(addr)));
        check("f_pc", pc, addr);
    endtask

    task automatic step(input logic [1:0] p, input logic [63:0] kk,
                        input logic [63:0] ra);
        ps    = p;
        k     = kk;
        reg_a = ra;
        stall = 1'b0;
        @(negedge clock);
        ps = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [31:0] held;

    initial begin
        reset      = 1'b0;
        ps         = 2'b00;
        k          = '0;
        reg_a      = '0;
        stall      = 1'b0;
        imem_rdata = word(RST_PC);
        imem_ack   = 1'b1;
        @(negedge clock);

        // 1: reset with ack tied high
        do_reset();
        check("rst_req", 64'(imem_req), 64'd1);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        @(negedge clock);
        imem_ack = 1'b0;
        check("t1_instr", 64'(instr), 64'(word(RST_PC)));
        check("t1_valid", 64'(instr_valid), 64'd1);
        check("t1_pc", pc, RST_PC);

        // 2: sequential with two wait states
        step(2'b01, '0, '0);
        fetch(2, 64'h104);
        step(2'b01, '0, '0);
        fetch(2, 64'h108);
        step(2'b01, '0, '0);
        fetch(2, 64'h10C);

        // 3: relative branches, including negative wrap
        step(2'b10, '0, 64'h200);
        fetch(0, 64'h200);
        step(2'b11, 64'hFFFF_FFFF_FFFF_FFFC, '0);
        fetch(1, 64'h1F0);
        step(2'b10, '0, 64'h0);
        fetch(0, 64'h0);
        step(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, '0);
        check("t3_nofault", 64'(fault), 64'd0);
        fetch(0, 64'hFFFF_FFFF_FFFF_FFFC);
        step(2'b01, '0, '0);
        check("wrap_nofault", 64'(fault), 64'd0);
        fetch(0, 64'h0);

        // 4: register branch then misaligned target
        step(2'b10, '0, 64'h3000);
        fetch(0, 64'h3000);
        step(2'b10, '0, 64'h3002);
        check("t4_fault", 64'(fault), 64'd1);
        check("t4_pc", pc, 64'h3000);
        check("t4_req", 64'(imem_req), 64'd0);
        check("t4_valid", 64'(instr_valid), 64'd0);
        ps       = 2'b01;
        imem_ack = 1'b1;
        @(negedge clock);
        @(negedge clock);
        imem_ack = 1'b0;
        ps       = 2'b00;
        check("t4_sticky", 64'(fault), 64'd1);
        check("t4_pc_hold", pc, 64'h3000);
        do_reset();
        check("t4_clr", 64'(fault), 64'd0);
        check("t4_rpc", pc, RST_PC);
        fetch(0, RST_PC);

        // 5: stall, then halt loop with stray ack
        held  = instr;
        stall = 1'b1;
        ps    = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("st_pc", pc, RST_PC);
            check("st_instr", 64'(instr), 64'(held));
            check("st_valid", 64'(instr_valid), 64'd1);
            check("st_req", 64'(imem_req), 64'd0);
        end
        stall = 1'b0;
        @(negedge clock);
        ps = 2'b00;
        fetch(0, 64'h104);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("h_valid", 64'(instr_valid), 64'd1);
            check("h_pc", pc, 64'h104);
            check("h_instr", 64'(instr), 64'(word(64'h104)));
            check("h_req", 64'(imem_req), 64'd0);
        end
        imem_ack = 1'b0;

        // 6: reset during fetch with simultaneous ack
        step(2'b01, '0, '0);
        check("t6_req", 64'(imem_req), 64'd1);
        check("t6_addr", imem_addr, 64'h108);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = word(64'h108);
        @(negedge clock);
        reset    = 1'b0;
        imem_ack = 1'b0;
        check("t6_valid", 64'(instr_valid), 64'd0);
        check("t6_instr", 64'(instr), 64'd0);
        check("t6_pc", pc, RST_PC);
        fetch(0, RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
